// File: rtl/i2c_txn_arbiter_if.sv
// i2c_txn_arbiter_if: requester-side and core-side signals of the I2C transaction arbiter
// Requester side: req/req_wr/req_addr/req_din in, gnt/ack/err/rdata/busy out.
// Core side: core_rstn/core_wr/core_addr/core_din out, core_datard/core_done in.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the core.
interface i2c_txn_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_wr;
  logic [7*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic err;
  logic [7:0] rdata;
  logic busy;
  logic core_rstn;
  logic core_wr;
  logic [6:0] core_addr;
  logic [7:0] core_din;
  logic [7:0] core_datard;
  logic core_done;
  modport slave(
    input req, req_wr, req_addr, req_din, core_datard, core_done,
    output gnt, ack, err, rdata, busy, core_rstn, core_wr, core_addr, core_din
  );
  modport master(
    output req, req_wr, req_addr, req_din, core_datard, core_done,
    input gnt, ack, err, rdata, busy, core_rstn, core_wr, core_addr, core_din
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one free-running I2C core, which is parked in reset between transactions
// Ports: clk and rst (asynchronous, active-high), and bus (i2c_txn_arbiter_if.slave).
// The bus interface carries the requester handshake and the core controls.
module i2c_txn_arbiter #(
  parameter int NREQ = 4,
  parameter int GUARD = 4,
  parameter int TIMEOUT = 255,
  parameter int RST_CYC = 2
) (
  input logic clk,
  input logic rst,
  i2c_txn_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GUARD + 2);
  localparam int RW = RST_CYC > 1 ? $clog2(RST_CYC) : 1;
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, LAUNCH = 3'd2, WAIT = 3'd3, RESP = 3'd4, RECOVER = 3'd5;
  logic [2:0] state;
  logic [IW-1:0] rr_ptr, win;
  logic found, done_ok;
  logic [GW-1:0] guard;
  logic [7:0] tmo;
  logic [RW-1:0] rc;
  // The scan runs from the farthest slot down to rr_ptr+1, so the last hit is the nearest requester after rr_ptr.
  always_comb begin
    win = rr_ptr;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--)
      if (bus.req[(int'(rr_ptr) + k) % NREQ]) begin
        win = IW'((int'(rr_ptr) + k) % NREQ);
        found = 1'b1;
      end
  end
  // The core may pulse done spuriously right after it leaves reset, so done is trusted only once the guard window has passed.
  assign done_ok = bus.core_done && guard >= GW'(GUARD);
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= IW'(NREQ - 1);
      guard <= '0;
      tmo <= '0;
      rc <= '0;
      bus.gnt <= '0;
      bus.ack <= '0;
      bus.err <= 1'b0;
      bus.rdata <= '0;
      bus.core_rstn <= 1'b0;
      bus.core_wr <= 1'b0;
      bus.core_addr <= '0;
      bus.core_din <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: if (|bus.req) state <= ARB;
        ARB: begin
          state <= found ? LAUNCH : IDLE;
          if (found) begin
            rr_ptr <= win;
            bus.gnt <= NREQ'(1) << win;
            bus.core_wr <= bus.req_wr[win];
            bus.core_addr <= bus.req_addr[int'(win) * 7 +: 7];
            bus.core_din <= bus.req_din[int'(win) * 8 +: 8];
          end
        end
        LAUNCH: begin
          bus.core_rstn <= 1'b1;
          guard <= '0;
          tmo <= '0;
          state <= WAIT;
        end
        WAIT: begin
          guard <= guard + GW'(guard < GW'(GUARD));
          tmo <= tmo + 8'd1;
          if (done_ok || tmo == 8'(TIMEOUT)) begin
            state <= RESP;
            bus.ack <= bus.gnt;
            bus.err <= !done_ok;
            if (done_ok && !bus.core_wr) bus.rdata <= bus.core_datard;
          end
        end
        RESP: begin
          state <= RECOVER;
          bus.gnt <= '0;
          bus.core_rstn <= 1'b0;
          rc <= '0;
        end
        RECOVER: begin
          rc <= rc + 1'b1;
          if (rc == RW'(RST_CYC - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: randomized self-checking bench for i2c_txn_arbiter with a behavioural core and arbitration model
module tb_i2c_txn_arbiter;
  localparam int N = 4, G = 4, TO = 255, RC = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  i2c_txn_arbiter_if #(.NREQ(N)) bus();
  i2c_txn_arbiter #(.NREQ(N), .GUARD(G), .TIMEOUT(TO), .RST_CYC(RC)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int total = 0, bad = 0;
  int d_at = -1;
  bit burst = 1'b0;
  logic [7:0] rd_val = 8'h00;
  int wc = 0;
  int last = N - 1;
  logic [7:0] rdata_m = 8'h00;
  always @(negedge clk) begin
    if (bus.core_rstn) begin
      bus.core_done = (burst && wc < 3) || (d_at >= 0 && wc >= d_at);
      wc++;
    end else begin
      bus.core_done = 1'b0;
      wc = 0;
    end
    bus.core_datard = rd_val;
  end
  function automatic bit sched(int w);
    return (burst && w < 3) || (d_at >= 0 && w >= d_at);
  endfunction
  function automatic int exp_exit();
    for (int w = 0; w < TO; w++) if (sched(w) && w >= G) return w;
    return TO;
  endfunction
  function automatic int pick(logic [N-1:0] r);
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic txn(input logic [N-1:0] rq, input bit keep, input int fi, input logic fw,
                     input logic [6:0] fa, input logic [7:0] fd, input string nm);
    int win, ex, lat, cyc, unst;
    bit idle0, err_e;
    logic [N-1:0] exp_g;
    logic [6:0] ea;
    logic [7:0] ed;
    logic ew;
    idle0 = !bus.busy;
    bus.req_wr = N'($urandom);
    bus.req_addr = (7*N)'($urandom);
    bus.req_din = (8*N)'($urandom);
    if (fi >= 0) begin
      bus.req_wr[fi] = fw;
      bus.req_addr[fi*7 +: 7] = fa;
      bus.req_din[fi*8 +: 8] = fd;
    end
    win = pick(rq);
    exp_g = N'(1) << win;
    ew = bus.req_wr[win];
    ea = bus.req_addr[win*7 +: 7];
    ed = bus.req_din[win*8 +: 8];
    ex = exp_exit();
    err_e = !(sched(ex) && ex >= G);
    if (!err_e && !ew) rdata_m = rd_val;
    bus.req = rq;
    lat = 0;
    while (!bus.core_rstn && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (!bus.core_rstn || (idle0 && lat != 3)) begin
      bad++;
      $display("FAIL %s launch latency got=%0d exp=3 core_rstn=%b", nm, lat, bus.core_rstn);
    end
    total++;
    if (bus.gnt !== exp_g) begin
      bad++;
      $display("FAIL %s gnt got=%b exp=%b", nm, bus.gnt, exp_g);
    end
    total++;
    if ({bus.core_wr, bus.core_addr, bus.core_din} !== {ew, ea, ed}) begin
      bad++;
      $display("FAIL %s core_cmd got=%b/%h/%h exp=%b/%h/%h", nm, bus.core_wr, bus.core_addr, bus.core_din, ew, ea, ed);
    end
    bus.req_wr = N'($urandom);
    bus.req_addr = (7*N)'($urandom);
    bus.req_din = (8*N)'($urandom);
    if (!keep) bus.req = '0;
    cyc = 1;
    unst = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (bus.ack != '0) break;
      if ({bus.core_wr, bus.core_addr, bus.core_din} !== {ew, ea, ed} || !bus.core_rstn) unst++;
      cyc++;
    end
    total++;
    if (cyc != ex + 1) begin
      bad++;
      $display("FAIL %s wait_cycles got=%0d exp=%0d", nm, cyc, ex + 1);
    end
    total++;
    if (unst != 0) begin
      bad++;
      $display("FAIL %s core_stable unstable_cycles got=%0d exp=0", nm, unst);
    end
    total++;
    if (bus.ack !== exp_g || bus.gnt !== exp_g) begin
      bad++;
      $display("FAIL %s ack/gnt got=%b/%b exp=%b", nm, bus.ack, bus.gnt, exp_g);
    end
    total++;
    if (bus.err !== err_e) begin
      bad++;
      $display("FAIL %s err got=%b exp=%b", nm, bus.err, err_e);
    end
    total++;
    if (bus.rdata !== rdata_m) begin
      bad++;
      $display("FAIL %s rdata got=%h exp=%h", nm, bus.rdata, rdata_m);
    end
    last = win;
    @(negedge clk);
    total++;
    if (bus.ack !== '0 || bus.gnt !== '0 || bus.core_rstn !== 1'b0) begin
      bad++;
      $display("FAIL %s recover ack/gnt/core_rstn got=%b/%b/%b exp=0/0/0", nm, bus.ack, bus.gnt, bus.core_rstn);
    end
    if (!keep) begin
      lat = 0;
      while (bus.busy && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      total++;
      if (lat != RC) begin
        bad++;
        $display("FAIL %s recover_len got=%0d exp=%0d", nm, lat, RC);
      end
    end
  endtask
  task automatic test_reset();
    #1;
    total++;
    if ({bus.gnt, bus.ack, bus.err, bus.rdata, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset gnt/ack/err/rdata/busy got=%b/%b/%b/%h/%b exp=0", bus.gnt, bus.ack, bus.err, bus.rdata, bus.busy);
    end
    total++;
    if ({bus.core_rstn, bus.core_wr, bus.core_addr, bus.core_din} !== '0) begin
      bad++;
      $display("FAIL reset core got=%b/%b/%h/%h exp=0", bus.core_rstn, bus.core_wr, bus.core_addr, bus.core_din);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_write();
    d_at = 20;
    burst = 1'b0;
    txn(4'b0010, 1'b0, 1, 1'b1, 7'h15, 8'hA5, "write");
  endtask
  task automatic test_read();
    d_at = 20;
    burst = 1'b0;
    rd_val = 8'hA5;
    txn(4'b0100, 1'b0, 2, 1'b0, 7'h15, 8'h00, "read");
  endtask
  task automatic test_timeout();
    d_at = -1;
    burst = 1'b0;
    rd_val = 8'h3C;
    txn(4'b1000, 1'b0, 3, 1'b0, 7'h2A, 8'h00, "timeout");
    d_at = 7;
    txn(4'b1000, 1'b0, 3, 1'b0, 7'h2B, 8'h00, "after_timeout");
  endtask
  task automatic test_guard();
    burst = 1'b1;
    d_at = 10;
    rd_val = 8'h5A;
    txn(4'b0001, 1'b0, 0, 1'b0, 7'h11, 8'h00, "guard");
    burst = 1'b0;
    d_at = 0;
    txn(4'b0001, 1'b0, 0, 1'b1, 7'h12, 8'h33, "guard_edge");
  endtask
  task automatic test_reset_mid();
    int lat, acks;
    d_at = -1;
    burst = 1'b0;
    bus.req = 4'b0100;
    lat = 0;
    while (!bus.core_rstn && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.gnt !== '0 || bus.core_rstn !== 1'b0 || bus.busy !== 1'b0 || lat >= 20) begin
      bad++;
      $display("FAIL reset_mid gnt/core_rstn/busy got=%b/%b/%b exp=0/0/0 launch_wait=%0d", bus.gnt, bus.core_rstn, bus.busy, lat);
    end
    bus.req = '0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
    end
    rst = 1'b0;
    rdata_m = 8'h00;
    last = N - 1;
    repeat (2) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
    end
    total++;
    if (acks != 0) begin
      bad++;
      $display("FAIL reset_mid ack_pulses got=%0d exp=0", acks);
    end
  endtask
  task automatic test_fairness();
    int lat;
    d_at = 6;
    burst = 1'b0;
    rd_val = 8'hC3;
    for (int i = 0; i < 6; i++) txn(4'b1011, 1'b1, -1, 1'b0, 7'h00, 8'h00, "fair");
    bus.req = '0;
    lat = 0;
    while (bus.busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL fair_idle busy got=%b exp=0", bus.busy);
    end
  endtask
  task automatic test_random();
    logic [N-1:0] rq;
    for (int i = 0; i < 12; i++) begin
      rq = N'($urandom_range(1, (1 << N) - 1));
      d_at = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 30));
      burst = 1'($urandom_range(0, 1));
      rd_val = 8'($urandom);
      txn(rq, 1'b0, -1, 1'b0, 7'h00, 8'h00, "random");
    end
  endtask
  initial begin
    bus.req = '0;
    bus.req_wr = '0;
    bus.req_addr = '0;
    bus.req_din = '0;
    bus.core_done = 1'b0;
    bus.core_datard = '0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_guard();
    test_reset_mid();
    test_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
